mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_if.sv | 25 ++
 rtl/mul_arbiter.sv | 127 ++++++++++++
 tb/tb_mul_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// Bundle of requester, consumer and shared-multiplier signals for mul_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mul_arbiter_if;
  logic        s0_valid, s0_ready;
  logic [31:0] s0_a, s0_b;
  logic        s1_valid, s1_ready;
  logic [31:0] s1_a, s1_b;
  logic        m0_valid, m0_ready;
  logic [62:0] m0_r;
  logic        m1_valid, m1_ready;
  logic [62:0] m1_r;
  logic [31:0] mul_a, mul_b;
  logic [62:0] mul_r;
  logic        busy;

  modport slave (
    input  s0_valid, s0_a, s0_b, s1_valid, s1_a, s1_b, m0_ready, m1_ready, mul_r,
    output s0_ready, s1_ready, m0_valid, m0_r, m1_valid, m1_r, mul_a, mul_b, busy
  );

  modport master (
    output s0_valid, s0_a, s0_b, s1_valid, s1_a, s1_b, m0_ready, m1_ready, mul_r,
    input  s0_ready, s1_ready, m0_valid, m0_r, m1_valid, m1_r, mul_a, mul_b, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Two-port round-robin front end for a shared pipelined multiplier; accept-to-result LATENCY+1 edges.
// Requesters are throttled by per-port credits so the result FIFOs can never overflow; m_ready never feeds s_ready.
module mul_arbiter #(
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_arbiter_if.slave bus
);

  localparam int              CW      = $clog2(LATENCY + OUT_DEPTH + 2) + 1;
  localparam int              PW      = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(OUT_DEPTH);
  localparam logic [PW-1:0]   LAST_C  = PW'(OUT_DEPTH - 1);

  logic [1:0]          s_vld, s_rdy, m_rdy, m_vld;
  logic [1:0][31:0]    s_a, s_b;

  logic                init_q;
  logic                last_q, last_d;
  logic [LATENCY:0]    tag_vld_q, tag_vld_d, tag_port_q, tag_port_d;
  logic [31:0]         mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d, infl;
  logic [1:0][PW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [62:0]         mem_q [2][OUT_DEPTH];

  logic [1:0]          elig, push, pop;
  logic                gnt_vld, gnt_port;

  assign s_vld = {bus.s1_valid, bus.s0_valid};
  assign s_a   = {bus.s1_a, bus.s0_a};
  assign s_b   = {bus.s1_b, bus.s0_b};
  assign m_rdy = {bus.m1_ready, bus.m0_ready};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LAST_C) ? '0 : ptr + PW'(1);
  endfunction

  always_comb begin
    infl       = '0;
    elig       = '0;
    s_rdy      = '0;
    push       = '0;
    pop        = '0;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;

    // Outstanding work per port = tagged ops still in the multiplier + buffered results.
    for (int k = 0; k <= LATENCY; k++) begin
      if (tag_vld_q[k]) infl[tag_port_q[k]] = infl[tag_port_q[k]] + CW'(1);
    end
    for (int p = 0; p < 2; p++) begin
      elig[p] = init_q && s_vld[p] && ((cnt_q[p] + infl[p]) < DEPTH_C);
    end

    gnt_vld  = |elig;
    gnt_port = (&elig) ? ~last_q : elig[1];
    if (gnt_vld) begin
      s_rdy[gnt_port] = 1'b1;
      mul_a_d         = s_a[gnt_port];
      mul_b_d         = s_b[gnt_port];
    end
    last_d     = gnt_vld ? gnt_port : last_q;
    tag_vld_d  = {tag_vld_q[LATENCY-1:0], gnt_vld};
    tag_port_d = {tag_port_q[LATENCY-1:0], gnt_port};

    for (int p = 0; p < 2; p++) begin
      push[p]  = tag_vld_q[LATENCY] && (tag_port_q[LATENCY] == 1'(p));
      pop[p]   = m_vld[p] && m_rdy[p];
      cnt_d[p] = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
      if (push[p]) wr_d[p] = ptr_inc(wr_q[p]);
      if (pop[p])  rd_d[p] = ptr_inc(rd_q[p]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      last_q     <= 1'b1;
      tag_vld_q  <= '0;
      tag_port_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      init_q     <= 1'b1;
      last_q     <= last_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Result storage needs no reset: counts gate visibility.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem_q[p][wr_q[p]] <= bus.mul_r;
      if (rst_n) assert (!(push[p] && !pop[p] && (cnt_q[p] == DEPTH_C)));
    end
  end

  always_comb begin
    m_vld[0] = (cnt_q[0] != '0);
    m_vld[1] = (cnt_q[1] != '0);
  end

  assign bus.s0_ready = s_rdy[0];
  assign bus.s1_ready = s_rdy[1];
  assign bus.m0_valid = m_vld[0];
  assign bus.m1_valid = m_vld[1];
  assign bus.m0_r     = mem_q[0][rd_q[0]];
  assign bus.m1_r     = mem_q[1][rd_q[1]];
  assign bus.mul_a    = mul_a_q;
  assign bus.mul_b    = mul_b_q;
  assign bus.busy     = (|tag_vld_q) || m_vld[0] || m_vld[1];

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomised and directed bench for mul_arbiter against a per-port outstanding-queue model.
module tb_mul_arbiter;
  localparam int LAT   = 2;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_arbiter_if bus();

  mul_arbiter #(.LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [62:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b};
    return full[62:0];
  endfunction

  // Shared multiplier: LAT register stages after it samples mul_a/mul_b.
  logic [62:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= ref_mul(bus.mul_a, bus.mul_b);
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign bus.mul_r = mp[LAT-1];

  typedef struct {
    logic [62:0] v;
    int          t;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  int    cyc;
  bit    last_g;
  int    n_cmp = 0;
  int    n_err = 0;
  int    accepted = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Called at a falling edge; drives inputs, checks outputs, advances the model over one rising edge.
  task automatic step(input bit v0, input bit v1,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input bit r0, input bit r1);
    bit el0, el1, gv, g, e_mv0, e_mv1;
    bus.s0_valid = v0; bus.s0_a = a0; bus.s0_b = b0;
    bus.s1_valid = v1; bus.s1_a = a1; bus.s1_b = b1;
    bus.m0_ready = r0; bus.m1_ready = r1;
    #1;
    el0   = v0 && (cyc > 0) && (q0.size() < DEPTH);
    el1   = v1 && (cyc > 0) && (q1.size() < DEPTH);
    gv    = el0 || el1;
    g     = (el0 && el1) ? !last_g : el1;
    e_mv0 = (q0.size() > 0) && (q0[0].t <= cyc);
    e_mv1 = (q1.size() > 0) && (q1[0].t <= cyc);
    chk("s0_ready", 64'(bus.s0_ready), 64'(gv && !g));
    chk("s1_ready", 64'(bus.s1_ready), 64'(gv && g));
    chk("m0_valid", 64'(bus.m0_valid), 64'(e_mv0));
    chk("m1_valid", 64'(bus.m1_valid), 64'(e_mv1));
    chk("busy", 64'(bus.busy), 64'((q0.size() + q1.size()) > 0));
    if (e_mv0) chk("m0_r", 64'(bus.m0_r), 64'(q0[0].v));
    if (e_mv1) chk("m1_r", 64'(bus.m1_r), 64'(q1[0].v));
    @(posedge clk);
    cyc++;
    if (e_mv0 && r0) void'(q0.pop_front());
    if (e_mv1 && r1) void'(q1.pop_front());
    if (gv && !g) begin q0.push_back('{ref_mul(a0, b0), cyc + LAT + 1}); accepted++; end
    if (gv && g)  begin q1.push_back('{ref_mul(a1, b1), cyc + LAT + 1}); accepted++; end
    if (gv) last_g = g;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r0, input bit r1);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0, r0, r1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.s0_valid = 1'b1; bus.s1_valid = 1'b1;
    bus.m0_ready = 1'b1; bus.m1_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s0_ready", 64'(bus.s0_ready), 64'd0);
    chk("rst_s1_ready", 64'(bus.s1_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
    q0.delete(); q1.delete();
    cyc    = 0;
    last_g = 1'b1;
    rst_n  = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int target;
    bus.s0_a = '0; bus.s0_b = '0; bus.s1_a = '0; bus.s1_b = '0;
    @(negedge clk);
    do_reset();

    // Single op 3*5 on port 0; first cycle after release never accepts.
    step(1'b1, 1'b0, 32'd3, 32'd5, '0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'd3, 32'd5, '0, '0, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    #1;
    chk("single_valid", 64'(bus.m0_valid), 64'd1);
    chk("single_r", 64'(bus.m0_r), 64'd15);
    idle(3, 1'b1, 1'b1);

    // Both ports saturated: alternation checked every cycle by the model.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 32'(i + 1), 32'(i + 100), 32'(i + 7), 32'(i + 1000), 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);

    // Port 1 consumer stalled: port 1 credit exhausts, port 0 continues.
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 32'(i), 32'(3 * i), 32'(i + 50), 32'(i + 9), 1'b1, 1'b0);
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 32'(i), 32'(5 * i), 32'(i + 70), 32'(i + 2), 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);

    // Largest operands on port 1, held at the FIFO head.
    step(1'b0, 1'b1, '0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);
    #1;
    chk("max_valid", 64'(bus.m1_valid), 64'd1);
    chk("max_r", 64'(bus.m1_r), 64'h7FFF_FFFE_0000_0001);
    idle(4, 1'b1, 1'b1);

    // Reset mid-cycle with one result buffered and two ops in flight.
    step(1'b1, 1'b0, 32'd11, 32'd13, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, '0, 32'd17, 32'd19, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, '0, 32'd23, 32'd29, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_m0_valid", 64'(bus.m0_valid), 64'd1);
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    bus.s0_valid = 1'b1; bus.s1_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m0_valid", 64'(bus.m0_valid), 64'd0);
    chk("mid_rst_s0_ready", 64'(bus.s0_ready), 64'd0);
    chk("mid_rst_s1_ready", 64'(bus.s1_ready), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    do_reset();
    idle(6, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'd7, 32'd6, '0, '0, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b1);
    #1;
    chk("post_rst_r", 64'(bus.m0_r), 64'd42);
    idle(3, 1'b1, 1'b1);

    // Random traffic on all four handshakes.
    target = accepted + 10000;
    for (int i = 0; i < 40000 && accepted < target; i++) begin
      logic [31:0] a0, b0, a1, b1;
      a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b0 = $urandom;
      a1 = $urandom;
      b1 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a0, b0, a1, b1,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end
    chk("random_ops_done", 64'(accepted >= target), 64'd1);
    idle(10, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
